// File: rtl/vu_vmu_addr_gen.sv
// Vector-memory-unit load address generator: expands a strided vector-load command into
// one credit-gated memory request per element. Optional sim checks: VU_VMU_ADDR_GEN_CHECK_EN.
module vu_vmu_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int VLEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic [VLEN_W-1:0] cmd_vlen,
    input  logic              credit_ready,
    output logic              credit_take,
    output logic              req_val,
    input  logic              req_rdy,
    output logic [ADDR_W-1:0] req_addr,
    output logic [VLEN_W-1:0] req_tag,
    output logic              busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [VLEN_W-1:0] ONE = VLEN_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] stride, stride_nxt;
    logic [VLEN_W-1:0] vlen, vlen_nxt;
    logic [VLEN_W-1:0] idx, idx_nxt;
    logic              fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= '0;
            stride <= '0;
            vlen   <= '0;
            idx    <= '0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            stride <= stride_nxt;
            vlen   <= vlen_nxt;
            idx    <= idx_nxt;
        end
    end

    // req_val depends only on state and credit, never on req_rdy
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        stride_nxt = stride;
        vlen_nxt   = vlen;
        idx_nxt    = idx;
        cmd_rdy    = 1'b0;
        busy       = 1'b0;
        req_val    = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val && cmd_vlen != '0) begin
                    addr_nxt   = cmd_base;
                    stride_nxt = cmd_stride;
                    vlen_nxt   = cmd_vlen;
                    idx_nxt    = '0;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                req_val = credit_ready;
                fire    = credit_ready & req_rdy;
                if (fire) begin
                    addr_nxt = addr + stride;
                    idx_nxt  = idx + ONE;
                    if (idx == vlen - ONE)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign credit_take = fire;
    assign req_addr    = addr;
    assign req_tag     = idx;

`ifdef VU_VMU_ADDR_GEN_CHECK_EN
`ifndef SYNTHESIS
    logic [10:0] busy_cmd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cmd_cnt <= '0;
        end else begin
            if (fire && !credit_ready)
                $display("%0t : vu_vmu_addr_gen : Error - request fired without credit", $time);
            if (busy && cmd_val) begin
                if (busy_cmd_cnt != 11'd1024)
                    busy_cmd_cnt <= busy_cmd_cnt + 11'd1;
                else
                    $display("%0t : vu_vmu_addr_gen : Error - cmd_val held while busy for over 1024 cycles", $time);
            end else begin
                busy_cmd_cnt <= '0;
            end
        end
    end
`endif
`endif

endmodule
